// File: rtl/ritc_pkg.sv
// Shared helpers for the RITC argmax tree: width derivation and the signed/unsigned
// compare used by the tree nodes, the trigger and the peak hold.
package ritc_pkg;

  function automatic int clogb2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // floor(log2(v)), used to find the depth of a heap-numbered tree node
  function automatic int flog2(input int v);
    int r;
    r = 0;
    while ((2 << r) <= v) r++;
    return r;
  endfunction

  function automatic int stages(input int n);
    return (n <= 1) ? 1 : clogb2(n);
  endfunction

  function automatic int idx_bits(input int n);
    return (clogb2(n) < 1) ? 1 : clogb2(n);
  endfunction

  function automatic int pos_bits(input int n);
    return (clogb2(n) < 1) ? 1 : clogb2(n);
  endfunction

  // Values arrive zero-extended; flipping bit w-1 maps two's complement order onto unsigned order.
  function automatic logic val_gt(input logic sgn, input logic [63:0] a, input logic [63:0] b,
                                  input int w);
    logic [63:0] m;
    m = sgn ? (64'd1 << (w - 1)) : 64'd0;
    return (a ^ m) > (b ^ m);
  endfunction

  // Left wins when present and (right absent or left >= right): ties go to the lower lane.
  function automatic logic left_wins(input logic sgn, input logic a_p, input logic b_p,
                                     input logic [63:0] a, input logic [63:0] b, input int w);
    return a_p && (!b_p || !val_gt(sgn, b, a, w));
  endfunction

endpackage

// File: rtl/ritc_argmax_node.sv
// One registered two-input compare of the argmax tree; the right operand's index
// gains bit LVL, which is the subtree-half select at this depth.
module ritc_argmax_node
  import ritc_pkg::*;
#(
  parameter int W   = 12,
  parameter int IW  = 4,
  parameter int LVL = 0,
  parameter int SGN = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [W-1:0]  a_val,
  input  logic          a_pres,
  input  logic [IW-1:0] a_idx,
  input  logic [W-1:0]  b_val,
  input  logic          b_pres,
  input  logic [IW-1:0] b_idx,
  output logic [W-1:0]  y_val,
  output logic          y_pres,
  output logic [IW-1:0] y_idx
);

  logic a_won;
  assign a_won = left_wins(SGN != 0, a_pres, b_pres, 64'(a_val), 64'(b_val), W);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      y_val  <= '0;
      y_pres <= 1'b0;
      y_idx  <= '0;
    end else if (a_won) begin
      y_val  <= a_val;
      y_pres <= a_pres;
      y_idx  <= a_idx;
    end else begin
      y_val  <= b_val;
      y_pres <= b_pres;
      y_idx  <= b_idx | (IW'(1) << LVL);
    end
  end

endmodule

// File: rtl/ritc_argmax_tree.sv
// Pipelined argmax over NUM_CORR correlation sums with threshold trigger and a
// windowed peak hold reporting best sum, lane and position per WINDOW_LEN samples.
module ritc_argmax_tree
  import ritc_pkg::*;
#(
  parameter int NUM_CORR   = 16,
  parameter int NUM_BITS   = 12,
  parameter int SIGNED     = 0,
  parameter int WINDOW_LEN = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               valid_i,
  input  logic [NUM_CORR*NUM_BITS-1:0]       corr_i,
  input  logic [NUM_BITS-1:0]                threshold_i,
  input  logic                               clear_i,
  output logic [NUM_BITS-1:0]                max_o,
  output logic [idx_bits(NUM_CORR)-1:0]      idx_o,
  output logic                               valid_o,
  output logic                               trig_o,
  output logic [NUM_BITS-1:0]                hold_max_o,
  output logic [idx_bits(NUM_CORR)-1:0]      hold_idx_o,
  output logic [pos_bits(WINDOW_LEN)-1:0]    hold_pos_o,
  output logic                               hold_valid_o
);

  localparam int S        = stages(NUM_CORR);
  localparam int IDX_BITS = idx_bits(NUM_CORR);
  localparam int POS_BITS = pos_bits(WINDOW_LEN);
  localparam int LEAVES   = 1 << S;
  localparam logic SGN    = (SIGNED != 0);

  // Heap numbering: node n has children 2n and 2n+1; leaves sit at LEAVES..2*LEAVES-1.
  logic [2*LEAVES-1:1][NUM_BITS-1:0] hv;
  logic [2*LEAVES-1:1]               hp;
  logic [2*LEAVES-1:1][S-1:0]        hi;

  for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
    if (k < NUM_CORR) begin : g_real
      assign hv[LEAVES+k] = corr_i[k*NUM_BITS +: NUM_BITS];
      assign hp[LEAVES+k] = 1'b1;
    end else begin : g_pad
      assign hv[LEAVES+k] = '0;
      assign hp[LEAVES+k] = 1'b0;
    end
    assign hi[LEAVES+k] = '0;
  end

  for (genvar n = 1; n < LEAVES; n++) begin : g_node
    ritc_argmax_node #(
      .W(NUM_BITS), .IW(S), .LVL(S - 1 - flog2(n)), .SGN(SIGNED)
    ) u_node (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .a_val (hv[2*n]),
      .a_pres(hp[2*n]),
      .a_idx (hi[2*n]),
      .b_val (hv[2*n+1]),
      .b_pres(hp[2*n+1]),
      .b_idx (hi[2*n+1]),
      .y_val (hv[n]),
      .y_pres(hp[n]),
      .y_idx (hi[n])
    );
  end

  logic [S:1] vld_q;
  logic [S:0] vld_pipe;
  assign vld_pipe = {vld_q, valid_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) vld_q <= '0;
    else       vld_q <= vld_pipe[S-1:0];
  end

  assign valid_o = vld_pipe[S];
  assign max_o   = hv[1];
  assign idx_o   = hi[1];
  assign trig_o  = valid_o & hp[1] & val_gt(SGN, 64'(max_o), 64'(threshold_i), NUM_BITS);

  logic [POS_BITS-1:0] pos_q, best_pos_q, nb_pos;
  logic [NUM_BITS-1:0] best_val_q, nb_val;
  logic [IDX_BITS-1:0] best_idx_q, nb_idx;
  logic                take, last;

  // nb_* is the best including the current sample, so the final window sample counts.
  always_comb begin
    take   = (pos_q == '0) || val_gt(SGN, 64'(max_o), 64'(best_val_q), NUM_BITS);
    nb_val = take ? max_o : best_val_q;
    nb_idx = take ? idx_o : best_idx_q;
    nb_pos = take ? pos_q : best_pos_q;
    last   = (pos_q == POS_BITS'(WINDOW_LEN - 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos_q        <= '0;
      best_val_q   <= '0;
      best_idx_q   <= '0;
      best_pos_q   <= '0;
      hold_max_o   <= '0;
      hold_idx_o   <= '0;
      hold_pos_o   <= '0;
      hold_valid_o <= 1'b0;
    end else begin
      hold_valid_o <= 1'b0;
      if (clear_i) begin
        pos_q <= '0;
      end else if (valid_o) begin
        best_val_q <= nb_val;
        best_idx_q <= nb_idx;
        best_pos_q <= nb_pos;
        if (last) begin
          hold_max_o   <= nb_val;
          hold_idx_o   <= nb_idx;
          hold_pos_o   <= nb_pos;
          hold_valid_o <= 1'b1;
          pos_q        <= '0;
        end else begin
          pos_q <= pos_q + POS_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ritc_argmax_tree.sv
// Bench for ritc_argmax_tree: an unsigned 16-lane/window-4 instance and a signed
// 5-lane/window-1 instance driven together, checked against a lane-scan reference.
module tb_ritc_argmax_tree;
  localparam int NA = 16, NB = 5, SA = 4, SB = 3, WA = 4, WB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, valid, clear;
  logic [11:0] thr_a, thr_b;
  logic [NA*12-1:0] corr_a;
  logic [NB*12-1:0] corr_b;

  logic [11:0] max_a, max_b, hmax_a, hmax_b;
  logic [3:0]  idx_a, hidx_a;
  logic [2:0]  idx_b, hidx_b;
  logic [1:0]  hpos_a;
  logic [0:0]  hpos_b;
  logic valid_a, valid_b, trig_a, trig_b, hv_a, hv_b;

  ritc_argmax_tree #(.NUM_CORR(NA), .NUM_BITS(12), .SIGNED(0), .WINDOW_LEN(WA)) dut_a (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .corr_i(corr_a), .threshold_i(thr_a),
    .clear_i(clear), .max_o(max_a), .idx_o(idx_a), .valid_o(valid_a), .trig_o(trig_a),
    .hold_max_o(hmax_a), .hold_idx_o(hidx_a), .hold_pos_o(hpos_a), .hold_valid_o(hv_a));

  ritc_argmax_tree #(.NUM_CORR(NB), .NUM_BITS(12), .SIGNED(1), .WINDOW_LEN(WB)) dut_b (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .corr_i(corr_b), .threshold_i(thr_b),
    .clear_i(clear), .max_o(max_b), .idx_o(idx_b), .valid_o(valid_b), .trig_o(trig_b),
    .hold_max_o(hmax_b), .hold_idx_o(hidx_b), .hold_pos_o(hpos_b), .hold_valid_o(hv_b));

  typedef struct {
    bit          v;
    logic [11:0] m;
    int          i;
  } samp_t;

  samp_t       pq[2][$];
  samp_t       win[2][$];
  bit          ehv[2];
  logic [11:0] ehm[2];
  int          ehi[2], ehp[2];
  int          tests = 0, fails = 0;
  logic [11:0] lanes[16];

  function automatic int sv(input logic [11:0] x, input bit sg);
    return sg ? int'($signed(x)) : int'(x);
  endfunction

  // Reference: scan lanes in order, keep the first strict maximum.
  function automatic samp_t ref_samp(input int d, input bit v);
    samp_t r;
    int n;
    bit sg;
    n = (d == 0) ? NA : NB;
    sg = (d == 1);
    r.v = v;
    r.i = 0;
    for (int k = 1; k < n; k++)
      if (sv(lanes[k], sg) > sv(lanes[r.i], sg)) r.i = k;
    r.m = lanes[r.i];
    return r;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input samp_t cur);
    logic [31:0] v, m, i, t, h, hm, hi, hp;
    logic [11:0] th;
    bit sg;
    if (d == 0) begin
      v = 32'(valid_a); m = 32'(max_a); i = 32'(idx_a); t = 32'(trig_a);
      h = 32'(hv_a); hm = 32'(hmax_a); hi = 32'(hidx_a); hp = 32'(hpos_a);
      th = thr_a; sg = 1'b0;
    end else begin
      v = 32'(valid_b); m = 32'(max_b); i = 32'(idx_b); t = 32'(trig_b);
      h = 32'(hv_b); hm = 32'(hmax_b); hi = 32'(hidx_b); hp = 32'(hpos_b);
      th = thr_b; sg = 1'b1;
    end
    chk("valid_o", d, v, 32'(cur.v));
    if (cur.v) begin
      chk("max_o", d, m, 32'(cur.m));
      chk("idx_o", d, i, 32'(cur.i));
    end
    chk("trig_o", d, t, 32'(cur.v && (sv(cur.m, sg) > sv(th, sg))));
    chk("hold_valid_o", d, h, 32'(ehv[d]));
    chk("hold_max_o", d, hm, 32'(ehm[d]));
    chk("hold_idx_o", d, hi, 32'(ehi[d]));
    chk("hold_pos_o", d, hp, 32'(ehp[d]));
  endtask

  task automatic hold_model(input int d, input samp_t cur, input bit clr);
    int wl;
    int bi;
    bit sg;
    wl = (d == 0) ? WA : WB;
    sg = (d == 1);
    ehv[d] = 1'b0;
    if (clr) win[d].delete();
    else if (cur.v) begin
      win[d].push_back(cur);
      if (win[d].size() == wl) begin
        bi = 0;
        for (int j = 1; j < wl; j++)
          if (sv(win[d][j].m, sg) > sv(win[d][bi].m, sg)) bi = j;
        ehv[d] = 1'b1;
        ehm[d] = win[d][bi].m;
        ehi[d] = win[d][bi].i;
        ehp[d] = bi;
        win[d].delete();
      end
    end
  endtask

  task automatic reset_model();
    samp_t z;
    z.v = 1'b0; z.m = '0; z.i = 0;
    for (int d = 0; d < 2; d++) begin
      pq[d].delete();
      repeat ((d == 0) ? SA : SB) pq[d].push_back(z);
      win[d].delete();
      ehv[d] = 1'b0; ehm[d] = '0; ehi[d] = 0; ehp[d] = 0;
    end
  endtask

  task automatic rst_chk();
    chk("rst_max", 0, 32'(max_a), 0);     chk("rst_max", 1, 32'(max_b), 0);
    chk("rst_idx", 0, 32'(idx_a), 0);     chk("rst_idx", 1, 32'(idx_b), 0);
    chk("rst_valid", 0, 32'(valid_a), 0); chk("rst_valid", 1, 32'(valid_b), 0);
    chk("rst_trig", 0, 32'(trig_a), 0);   chk("rst_trig", 1, 32'(trig_b), 0);
    chk("rst_hv", 0, 32'(hv_a), 0);       chk("rst_hv", 1, 32'(hv_b), 0);
    chk("rst_hmax", 0, 32'(hmax_a), 0);   chk("rst_hmax", 1, 32'(hmax_b), 0);
    chk("rst_hpos", 0, 32'(hpos_a), 0);   chk("rst_hidx", 0, 32'(hidx_a), 0);
  endtask

  // One cycle: check current outputs, advance the model, drive inputs, cross the edge.
  task automatic step(input bit v, input bit clr);
    samp_t cur;
    for (int d = 0; d < 2; d++) begin
      cur = pq[d].pop_front();
      check_dut(d, cur);
      hold_model(d, cur, clr);
      pq[d].push_back(ref_samp(d, v));
    end
    valid = v;
    clear = clr;
    for (int k = 0; k < NA; k++) corr_a[k*12 +: 12] = lanes[k];
    for (int k = 0; k < NB; k++) corr_b[k*12 +: 12] = lanes[k];
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [11:0] base);
    for (int k = 0; k < 16; k++) lanes[k] = base;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; clear = 1'b0; thr_a = '0; thr_b = '0;
    corr_a = '0; corr_b = '0;
    set_lanes(12'd0);
    #12;
    rst_chk();
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();

    // single winner on lane 11
    set_lanes(12'd5); lanes[11] = 12'h7FF; thr_a = 12'h100;
    step(1, 0); set_lanes(12'd0);
    repeat (3) step(0, 0);
    chk("t1_valid", 0, 32'(valid_a), 1);
    chk("t1_max", 0, 32'(max_a), 32'h7FF);
    chk("t1_idx", 0, 32'(idx_a), 11);

    // signed, all negative, padded lanes must never win
    set_lanes(12'd0); for (int k = 0; k < 4; k++) lanes[k] = 12'hFCE;
    lanes[4] = 12'hFFF; thr_b = 12'hF00;
    step(1, 0); set_lanes(12'd0);
    repeat (2) step(0, 0);
    chk("neg_valid", 1, 32'(valid_b), 1);
    chk("neg_max", 1, 32'(max_b), 32'hFFF);
    chk("neg_idx", 1, 32'(idx_b), 4);
    chk("neg_trig", 1, 32'(trig_b), 1);

    // tie between lanes 3 and 9, threshold just below and equal
    set_lanes(12'd0); lanes[3] = 12'd100; lanes[9] = 12'd100; thr_a = 12'd99;
    step(1, 0); set_lanes(12'd0);
    repeat (3) step(0, 0);
    chk("tie_max", 0, 32'(max_a), 100);
    chk("tie_idx", 0, 32'(idx_a), 3);
    chk("tie_trig99", 0, 32'(trig_a), 1);
    thr_a = 12'd100;
    #1;
    chk("tie_trig100", 0, 32'(trig_a), 0);

    // window of 10,40,40,7 with gaps
    step(0, 1);
    set_lanes(12'd0); lanes[2] = 12'd10; step(1, 0); step(0, 0);
    set_lanes(12'd0); lanes[5] = 12'd40; step(1, 0); step(0, 0); step(0, 0);
    set_lanes(12'd0); lanes[7] = 12'd40; step(1, 0);
    set_lanes(12'd0); step(0, 0);
    lanes[1] = 12'd7; step(1, 0); set_lanes(12'd0);
    repeat (4) step(0, 0);
    chk("win_hv", 0, 32'(hv_a), 1);
    chk("win_hmax", 0, 32'(hmax_a), 40);
    chk("win_hpos", 0, 32'(hpos_a), 1);
    chk("win_hidx", 0, 32'(hidx_a), 5);

    // clear coincident with the 3rd valid output of a window
    step(0, 1);
    set_lanes(12'd0);
    lanes[0] = 12'd90;  step(1, 0);
    lanes[0] = 12'd80;  step(1, 0);
    lanes[0] = 12'd200; step(1, 0);
    set_lanes(12'd0); repeat (3) step(0, 0);
    step(0, 1);
    for (int s = 1; s <= 4; s++) begin
      lanes[0] = 12'(s); step(1, 0);
    end
    set_lanes(12'd0);
    repeat (4) step(0, 0);
    chk("clr_hv", 0, 32'(hv_a), 1);
    chk("clr_hmax", 0, 32'(hmax_a), 4);
    chk("clr_hpos", 0, 32'(hpos_a), 3);

    // randomized traffic with an asynchronous reset in the middle
    thr_a = 12'($urandom); thr_b = 12'($urandom);
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 16; k++)
        lanes[k] = ($urandom_range(0, 2) == 0) ? 12'($urandom_range(0, 3)) : 12'($urandom);
      if (n == 200) begin
        valid = 1'b1;
        #3 rst = 1'b1;
        #1 rst_chk();
        valid = 1'b0; clear = 1'b0;
        @(posedge clk); #1;
        rst_chk();
        rst = 1'b0;
        reset_model();
      end
      step(1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end
    repeat (6) step(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ritc_argmax_tree.md
Name: ritc_argmax_tree

Overview:
Pipelined maximum-search tree over NUM_CORR correlation sums. It returns the winning value and the index of the winning lane, with valid tracking, signed/unsigned mode and a threshold trigger. A windowed peak-hold stage follows the tree and reports the best sum, lane and sample position per WINDOW_LEN valid samples. It sits after the RITC correlator bank and feeds the trigger/readout logic.

Parameters:
NUM_CORR, 16, number of correlation lanes (>=1)
NUM_BITS, 12, width of each correlation sum
SIGNED, 0, 1 = sums are two's complement; 0 = unsigned
WINDOW_LEN, 8, valid samples per peak-hold window (>=1)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
valid_i  in  1  corr_i holds a new sample this cycle
corr_i  in  NUM_CORR*NUM_BITS  lane k at bits [k*NUM_BITS +: NUM_BITS]
threshold_i  in  NUM_BITS  trigger threshold; uses the same signedness as corr_i; quasi-static
clear_i  in  1  synchronous restart of the peak-hold window
max_o  out  NUM_BITS  per-sample maximum
idx_o  out  IDX_BITS  lane index of max_o; IDX_BITS = max(1, clog2(NUM_CORR))
valid_o  out  1  max_o/idx_o valid
trig_o  out  1  valid_o && max_o > threshold_i
hold_max_o  out  NUM_BITS  window maximum
hold_idx_o  out  IDX_BITS  lane of window maximum
hold_pos_o  out  POS_BITS  sample position in window, 0..WINDOW_LEN-1; POS_BITS = max(1, clog2(WINDOW_LEN))
hold_valid_o  out  1  one-cycle strobe; hold_* are valid

Behaviour:
- Reset: rst_i asynchronously clears every pipeline register, valid bit, window counter and hold register. All outputs are 0 while rst_i is high and on the first edge after release.
- Tree:
  - S = clog2(NUM_CORR) registered stages; S = 1 when NUM_CORR = 1 (the single lane is registered once).
  - Latency is S cycles from valid_i to valid_o. Throughput is one sample per cycle.
- Lane padding: lanes NUM_CORR..2^S-1 carry a lane-present bit of 0 and never win. The result is always a real lane, including all-negative inputs in SIGNED mode.
- Node rule: the left operand wins if it is present and (the right operand is absent, or left >= right). Ties therefore resolve to the lower lane index. Comparison is signed when SIGNED = 1.
- Valid pipeline:
  - valid_i is delayed S cycles to form valid_o.
  - Data registers update every cycle regardless of valid.
  - When valid_o = 0, max_o/idx_o are don't-care but deterministic; trig_o is forced to 0.
- trig_o is combinational from the registered max_o and threshold_i; there is no added latency.
- Peak hold, updated on cycles with valid_o = 1:
  - pos counter 0..WINDOW_LEN-1.
  - At pos = 0, load best = max_o, idx_o, pos.
  - Otherwise replace best only if max_o > best (strict), so the first occurrence wins ties.
  - When pos = WINDOW_LEN-1: register the final best into hold_* (accounting for the current sample), pulse hold_valid_o for exactly one cycle on the next edge, and wrap pos to 0.
  - hold_* retain their value until the next window completes.
- clear_i:
  - Sets pos to 0 and discards the partial best.
  - If clear_i and valid_o occur in the same cycle, clear takes priority: the sample is dropped, and the next valid sample is position 0.
  - clear_i does not affect the tree or hold_* outputs already presented.
  - It suppresses a hold_valid_o that would fire from the same cycle.
- WINDOW_LEN = 1: every valid_o produces hold_valid_o one cycle later, with hold_pos_o = 0.
- Reset mid-window: the partial window is lost and counting restarts at 0 after release.
- valid_i gaps do not advance pos; a window spans any number of cycles.

Decomposition:
- Package ritc_pkg:
  - clogb2 function.
  - IDX_BITS/POS_BITS derivation.
  - S (stage count) helper.
  - The compare rule as a function taking the signed flag.
- Sub-module ritc_argmax_node: one registered two-input compare.
  - Inputs: a/b value, present bit, index.
  - Outputs: winner value, present bit, index extended by one bit.
  - Instantiated in a generate tree.
- Peak hold is inline in ritc_argmax_tree.

Test Plan:
- NUM_CORR=16 unsigned, lane 11 = 0x7FF, all others 5, one valid_i -> after 4 cycles valid_o=1, max_o=0x7FF, idx_o=11.
- Tie: lanes 3 and 9 = 100, rest 0 -> max_o=100, idx_o=3. Also threshold_i=99 -> trig_o=1; threshold_i=100 -> trig_o=0.
- SIGNED=1, NUM_CORR=5 (padded to 8), all lanes negative, lane 4 = -1, others -50 -> max_o=0xFFF, idx_o=4; padding never selected.
- WINDOW_LEN=4, valid sample maxima 10, 40, 40, 7 with valid gaps between them -> one hold_valid_o pulse, hold_max_o=40, hold_pos_o=1.
- clear_i asserted coincident with the 3rd valid sample of a window, samples 90, 80, 200, then 1, 2, 3, 4 -> no pulse for the aborted window. Next pulse reports hold_max_o=4, hold_pos_o=3.
- rst_i asserted asynchronously mid-window and mid-pipeline -> all outputs 0 immediately, no valid_o/hold_valid_o from pre-reset samples, and a new window starts at pos 0.
